// File: rtl/prbs_pkg.sv
// Shared definitions for the PRBS-15 pattern link (transmit block and link checker).
package prbs_pkg;

  localparam int PRBS_W    = 15;
  localparam int TAP_HI    = 14;
  localparam int TAP_LO    = 13;
  localparam int BYTE_W    = 8;
  localparam int PAT_BYTES = 4;

  localparam logic [PRBS_W-1:0] PRBS_SEED_DEFAULT = 15'h7FFF;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PATTERN = 2'd1,
    ST_PRBS    = 2'd2,
    ST_DONE    = 2'd3
  } tx_state_e;

  function automatic logic [BYTE_W-1:0] pattern_byte(input logic [31:0] word,
                                                     input logic [1:0]  idx);
    return word[BYTE_W*idx +: BYTE_W];
  endfunction

endpackage

// File: rtl/prbs_pattern_tx_lfsr.sv
// PRBS-15 (x^15+x^14+1) eight-step unroll; the first generated bit lands in byte_out[7].
module prbs15_lfsr
  import prbs_pkg::*;
(
  input  logic [PRBS_W-1:0] lfsr_state,
  output logic [PRBS_W-1:0] next_state,
  output logic [BYTE_W-1:0] byte_out
);

  always_comb begin
    logic [PRBS_W-1:0] s;
    logic              fb;
    s        = lfsr_state;
    fb       = 1'b0;
    byte_out = '0;
    for (int i = 0; i < BYTE_W; i++) begin
      fb                     = s[TAP_HI] ^ s[TAP_LO];
      byte_out[BYTE_W-1-i]   = fb;
      s                      = {s[PRBS_W-2:0], fb};
    end
    next_state = s;
  end

endmodule

// File: rtl/prbs_pattern_tx.sv
// Pattern/PRBS-15 transmitter: n repetitions of a 4-byte pattern, then PRBS_BYTES PRBS bytes,
// one byte per valid/ready beat, with byte_num/seq_num sideband matching the link checker.
module prbs_pattern_tx
  import prbs_pkg::*;
#(
  parameter int                PRBS_BYTES = 16,
  parameter logic [PRBS_W-1:0] SEED       = PRBS_SEED_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] pattern,
  input  logic [7:0]  n,
  input  logic        tx_ready,
  output logic [7:0]  data_out,
  output logic        data_valid,
  output logic [1:0]  byte_num,
  output logic [7:0]  seq_num,
  output logic        prbs_phase,
  output logic        busy,
  output logic        done
);

  localparam logic [7:0] LAST_PRBS = 8'(PRBS_BYTES - 1);

  tx_state_e          state_q, state_d;
  logic [31:0]        pat_q, pat_d;
  logic [7:0]         n_q, n_d;
  logic [PRBS_W-1:0]  lfsr_q, lfsr_d;
  logic [7:0]         prbs_cnt_q, prbs_cnt_d;
  logic [7:0]         data_out_q, data_out_d;
  logic               data_valid_q, data_valid_d;
  logic [1:0]         byte_num_q, byte_num_d;
  logic [7:0]         seq_num_q, seq_num_d;
  logic               prbs_phase_q, prbs_phase_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [PRBS_W-1:0]  lfsr_next_s;
  logic [BYTE_W-1:0]  lfsr_byte_s;
  logic               accept_s;
  logic [1:0]         byte_num_inc_s;

  // lfsr_q always holds the state the next presented PRBS byte is generated from;
  // it advances exactly once per byte, as that byte is put on data_out.
  prbs15_lfsr u_lfsr (
    .lfsr_state (lfsr_q),
    .next_state (lfsr_next_s),
    .byte_out   (lfsr_byte_s)
  );

  assign accept_s       = data_valid_q & tx_ready;
  assign byte_num_inc_s = byte_num_q + 2'd1;

  // Next-state and registered-output computation.
  always_comb begin
    state_d      = state_q;
    pat_d        = pat_q;
    n_d          = n_q;
    lfsr_d       = lfsr_q;
    prbs_cnt_d   = prbs_cnt_q;
    data_out_d   = data_out_q;
    data_valid_d = data_valid_q;
    byte_num_d   = byte_num_q;
    seq_num_d    = seq_num_q;
    prbs_phase_d = prbs_phase_q;
    busy_d       = busy_q;
    done_d       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          pat_d        = pattern;
          n_d          = n;
          prbs_cnt_d   = 8'd0;
          byte_num_d   = 2'd0;
          seq_num_d    = 8'd0;
          data_valid_d = 1'b1;
          busy_d       = 1'b1;
          if (n != 8'd0) begin
            state_d      = ST_PATTERN;
            lfsr_d       = SEED;
            data_out_d   = pattern[7:0];
            prbs_phase_d = 1'b0;
          end else begin
            state_d      = ST_PRBS;
            lfsr_d       = lfsr_next_s;
            data_out_d   = lfsr_byte_s;
            prbs_phase_d = 1'b1;
          end
        end else begin
          busy_d = 1'b0;
        end
      end

      ST_PATTERN: begin
        if (accept_s) begin
          if ((byte_num_q == 2'd3) && (seq_num_q == (n_q - 8'd1))) begin
            state_d      = ST_PRBS;
            byte_num_d   = 2'd0;
            seq_num_d    = 8'd0;
            prbs_phase_d = 1'b1;
            lfsr_d       = lfsr_next_s;
            data_out_d   = lfsr_byte_s;
          end else begin
            byte_num_d = byte_num_inc_s;
            data_out_d = pattern_byte(pat_q, byte_num_inc_s);
            if (byte_num_q == 2'd3) begin
              seq_num_d = seq_num_q + 8'd1;
            end else begin
              seq_num_d = seq_num_q;
            end
          end
        end else begin
          state_d = ST_PATTERN;
        end
      end

      ST_PRBS: begin
        if (accept_s) begin
          if (prbs_cnt_q == LAST_PRBS) begin
            state_d      = ST_DONE;
            data_valid_d = 1'b0;
            prbs_phase_d = 1'b0;
            data_out_d   = 8'd0;
            done_d       = 1'b1;
          end else begin
            prbs_cnt_d = prbs_cnt_q + 8'd1;
            lfsr_d     = lfsr_next_s;
            data_out_d = lfsr_byte_s;
          end
        end else begin
          state_d = ST_PRBS;
        end
      end

      ST_DONE: begin
        state_d    = ST_IDLE;
        busy_d     = 1'b0;
        lfsr_d     = SEED;
        prbs_cnt_d = 8'd0;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      pat_q        <= 32'd0;
      n_q          <= 8'd0;
      lfsr_q       <= SEED;
      prbs_cnt_q   <= 8'd0;
      data_out_q   <= 8'd0;
      data_valid_q <= 1'b0;
      byte_num_q   <= 2'd0;
      seq_num_q    <= 8'd0;
      prbs_phase_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pat_q        <= pat_d;
      n_q          <= n_d;
      lfsr_q       <= lfsr_d;
      prbs_cnt_q   <= prbs_cnt_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      byte_num_q   <= byte_num_d;
      seq_num_q    <= seq_num_d;
      prbs_phase_q <= prbs_phase_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign byte_num   = byte_num_q;
  assign seq_num    = seq_num_q;
  assign prbs_phase = prbs_phase_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_prbs_pattern_tx.sv
// Directed self-checking bench for prbs_pattern_tx: pattern/PRBS stream, backpressure,
// n=0, ignored restart, async reset mid-frame and n=255.
module tb_prbs_pattern_tx;

  localparam int PB = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] pattern;
  logic [7:0]  n;
  logic        tx_ready;
  logic [7:0]  data_out;
  logic        data_valid;
  logic [1:0]  byte_num;
  logic [7:0]  seq_num;
  logic        prbs_phase;
  logic        busy;
  logic        done;

  int tests_run    = 0;
  int tests_failed = 0;

  prbs_pattern_tx #(.PRBS_BYTES(PB), .SEED(15'h7FFF)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .pattern    (pattern),
    .n          (n),
    .tx_ready   (tx_ready),
    .data_out   (data_out),
    .data_valid (data_valid),
    .byte_num   (byte_num),
    .seq_num    (seq_num),
    .prbs_phase (prbs_phase),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // {valid, busy, done, prbs_phase, byte_num, seq_num, data_out}
  function automatic logic [31:0] obs();
    return {10'd0, data_valid, busy, done, prbs_phase, byte_num, seq_num, data_out};
  endfunction

  // Bit-serial reference: collect 8 feedback bits MSB first.
  function automatic logic [7:0] model_byte(input logic [14:0] s);
    logic [7:0] r;
    logic       b;
    r = 8'd0;
    for (int i = 0; i < 8; i++) begin
      b = s[14] ^ s[13];
      r = {r[6:0], b};
      s = {s[13:0], b};
    end
    return r;
  endfunction

  function automatic logic [14:0] model_adv(input logic [14:0] s);
    for (int i = 0; i < 8; i++) s = {s[13:0], s[14] ^ s[13]};
    return s;
  endfunction

  task automatic run_frame(input logic [31:0] pat, input logic [7:0] nn, input int stall_at,
                           input int stall_len, input bit disturb, input int abort_at);
    int          total;
    int          k;
    int          stalls;
    int          cyc;
    logic [14:0] ms;
    logic [31:0] exp;
    total  = 4 * int'(nn) + PB;
    k      = 0;
    stalls = stall_len;
    cyc    = 0;
    ms     = 15'h7FFF;
    @(negedge clk);
    pattern  = pat;
    n        = nn;
    start    = 1'b1;
    tx_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (k < total && cyc < total + stall_len + 8) begin
      if (k == abort_at) return;
      if (k < 4 * int'(nn))
        exp = {10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 2'(k % 4), 8'(k / 4), pat[8*(k%4) +: 8]};
      else
        exp = {10'd0, 1'b1, 1'b1, 1'b0, 1'b1, 2'd0, 8'd0, model_byte(ms)};
      check_val($sformatf("beat%0d", k), obs(), exp);
      if (k == 4 * int'(nn))     check_val("prbs_first",  {24'd0, data_out}, 32'h00);
      if (k == 4 * int'(nn) + 1) check_val("prbs_second", {24'd0, data_out}, 32'h02);
      if (disturb && k == 2) begin
        start   = 1'b1;
        pattern = ~pat;
        n       = nn + 8'd3;
      end else begin
        start = 1'b0;
      end
      if (k == stall_at && stalls > 0) begin
        tx_ready = 1'b0;
        stalls--;
      end else begin
        tx_ready = 1'b1;
        if (k >= 4 * int'(nn)) ms = model_adv(ms);
        k++;
      end
      cyc++;
      @(negedge clk);
    end
    start = 1'b0;
    check_val("beat_count", k, total);
    check_val("done_pulse", obs(), {10'd0, 1'b0, 1'b1, 1'b1, 19'd0});
    @(negedge clk);
    check_val("idle_after", obs(), 32'd0);
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    pattern  = 32'd0;
    n        = 8'd0;
    tx_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_val("reset_outputs", obs(), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_val("idle_outputs", obs(), 32'd0);

    run_frame(32'hDDCCBBAA, 8'd2, -1, 0, 1'b0, -1);
    run_frame(32'hDDCCBBAA, 8'd2,  2, 3, 1'b0, -1);
    run_frame(32'hDDCCBBAA, 8'd0, -1, 0, 1'b0, -1);
    run_frame(32'hDDCCBBAA, 8'd2, -1, 0, 1'b1, -1);

    run_frame(32'hDDCCBBAA, 8'd2, -1, 0, 1'b0, 11);
    check_val("pre_reset_prbs", {31'd0, prbs_phase}, 32'd1);
    #2 rst = 1'b1;
    #1 check_val("async_reset", obs(), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_frame(32'h04030201, 8'd1, -1, 0, 1'b0, -1);

    run_frame(32'h89ABCDEF, 8'd255, -1, 0, 1'b0, -1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
